// File: rtl/posit_pkg.sv
// Shared widths, field struct and helpers for the pipelined posit encoder (n=16, es=1).
package posit_pkg;

    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    localparam int POSIT_N    = 16;
    localparam int POSIT_ES   = 1;
    localparam int MANT_WIDTH = POSIT_N - POSIT_ES - 3;
    localparam int K_WIDTH    = clog2(POSIT_N - 1);
    localparam int TAG_WIDTH  = 4;

    // Body vector: a full-length regime run, terminator, exponent, fraction.
    localparam int KEPT_WIDTH = POSIT_N - 1;
    localparam int TAIL_WIDTH = 1 + POSIT_ES + MANT_WIDTH;
    localparam int VEC_WIDTH  = KEPT_WIDTH + TAIL_WIDTH;
    localparam int REM_WIDTH  = VEC_WIDTH - KEPT_WIDTH;
    localparam int RUN_WIDTH  = K_WIDTH + 2;

    typedef struct packed {
        logic                  sign;
        logic [K_WIDTH:0]      k;
        logic [POSIT_ES-1:0]   exp;
        logic [MANT_WIDTH:0]   mant;
        logic                  sticky;
        logic                  nar;
    } posit_fields_t;

endpackage

// File: rtl/posit_round_rne.sv
// Round-to-nearest-even of the shifted posit body plus saturation and nonzero clamp.
module posit_round_rne
    import posit_pkg::*;
(
    input  logic [VEC_WIDTH-1:0]  vec,
    input  logic                  sticky,
    input  logic                  sat,
    input  logic                  sat_hi,
    output logic [KEPT_WIDTH-1:0] mag,
    output logic                  saturated
);
    localparam logic [KEPT_WIDTH-1:0] MAG_MAX = {KEPT_WIDTH{1'b1}};
    localparam logic [KEPT_WIDTH-1:0] MAG_MIN = {{(KEPT_WIDTH-1){1'b0}}, 1'b1};

    logic [KEPT_WIDTH-1:0] kept_s;
    logic                  guard_s;
    logic                  rest_s;
    logic                  round_up_s;
    logic [KEPT_WIDTH:0]   sum_s;

    assign kept_s     = vec[VEC_WIDTH-1 -: KEPT_WIDTH];
    assign guard_s    = vec[REM_WIDTH-1];
    assign rest_s     = (|vec[REM_WIDTH-2:0]) | sticky;
    assign round_up_s = guard_s & (rest_s | kept_s[0]);
    assign sum_s      = {1'b0, kept_s} + {{KEPT_WIDTH{1'b0}}, round_up_s};

    // Saturate out-of-range regimes; a nonzero value never lands on 0 or NaR.
    always_comb begin
        mag       = sum_s[KEPT_WIDTH-1:0];
        saturated = 1'b0;
        if (sat) begin
            mag       = sat_hi ? MAG_MAX : MAG_MIN;
            saturated = 1'b1;
        end else if (sum_s[KEPT_WIDTH]) begin
            mag       = MAG_MAX;
            saturated = 1'b1;
        end else if (sum_s[KEPT_WIDTH-1:0] == {KEPT_WIDTH{1'b0}}) begin
            mag       = MAG_MIN;
            saturated = 1'b1;
        end else begin
            mag       = sum_s[KEPT_WIDTH-1:0];
            saturated = 1'b0;
        end
    end

endmodule

// File: rtl/posit_encoder_pipe.sv
// Two-stage valid/ready posit encoder: regime build and shift, then RNE rounding and packing.
// Define POSIT_ENC_SAT_CNT_EN to add the sat_cnt_o saturation event counter.
module posit_encoder_pipe
    import posit_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  sign_i,
    input  logic [K_WIDTH:0]      k_sgn_i,
    input  logic [POSIT_ES-1:0]   exp_i,
    input  logic [MANT_WIDTH:0]   mant_norm_i,
    input  logic                  sticky_i,
    input  logic                  is_nar_i,
    input  logic [TAG_WIDTH-1:0]  tag_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [POSIT_N-1:0]    result_o,
    output logic [TAG_WIDTH-1:0]  tag_o
`ifdef POSIT_ENC_SAT_CNT_EN
    ,
    output logic [15:0]           sat_cnt_o
`endif
);
    localparam logic [RUN_WIDTH-1:0] RUN_KEPT = RUN_WIDTH'(KEPT_WIDTH);
    localparam logic [RUN_WIDTH-1:0] RUN_ONE  = {{(RUN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [RUN_WIDTH-1:0] RUN_ZERO = {RUN_WIDTH{1'b0}};
    localparam logic [POSIT_N-1:0]   N_ONE    = {{(POSIT_N-1){1'b0}}, 1'b1};

    posit_fields_t          fields_s;
    logic                   run_pos_s;
    logic                   sat_s;
    logic [RUN_WIDTH-1:0]   k_ext_s;
    logic [RUN_WIDTH-1:0]   run_cnt_s;
    logic [RUN_WIDTH-1:0]   shamt_s;
    logic [VEC_WIDTH-1:0]   body_s;
    logic                   s2_ready_s;
    logic [KEPT_WIDTH-1:0]  mag_s;
    logic                   rnd_sat_s;
    logic [POSIT_N-1:0]     enc_s;

    logic                   s1_valid_r;
    logic [VEC_WIDTH-1:0]   s1_vec_r;
    logic                   s1_sat_r;
    logic                   s1_sat_hi_r;
    logic                   s1_zero_r;
    logic                   s1_nar_r;
    logic                   s1_sign_r;
    logic                   s1_sticky_r;
    logic [TAG_WIDTH-1:0]   s1_tag_r;

    assign fields_s   = {sign_i, k_sgn_i, exp_i, mant_norm_i, sticky_i, is_nar_i};
    assign run_pos_s  = ~fields_s.k[K_WIDTH];
    assign k_ext_s    = {{(RUN_WIDTH-K_WIDTH-1){fields_s.k[K_WIDTH]}}, fields_s.k};
    assign s2_ready_s = ~out_valid_o | out_ready_i;
    assign in_ready_o = ~s1_valid_r | s2_ready_s;

    // Run length excludes the terminator; dropping leading run bits left-aligns the regime.
    always_comb begin
        run_cnt_s = RUN_ZERO;
        shamt_s   = RUN_ZERO;
        if (run_pos_s) begin
            run_cnt_s = k_ext_s + RUN_ONE;
        end else begin
            run_cnt_s = RUN_ZERO - k_ext_s;
        end
        sat_s = (run_cnt_s >= RUN_KEPT);
        if (sat_s) begin
            shamt_s = RUN_ZERO;
        end else begin
            shamt_s = RUN_KEPT - run_cnt_s;
        end
        body_s = {{KEPT_WIDTH{run_pos_s}}, ~run_pos_s, fields_s.exp, fields_s.mant[MANT_WIDTH-1:0]};
    end

    // Stage 1: shifted body and flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_r  <= 1'b0;
            s1_vec_r    <= {VEC_WIDTH{1'b0}};
            s1_sat_r    <= 1'b0;
            s1_sat_hi_r <= 1'b0;
            s1_zero_r   <= 1'b0;
            s1_nar_r    <= 1'b0;
            s1_sign_r   <= 1'b0;
            s1_sticky_r <= 1'b0;
            s1_tag_r    <= {TAG_WIDTH{1'b0}};
        end else if (in_ready_o) begin
            s1_valid_r <= in_valid_i;
            if (in_valid_i) begin
                s1_vec_r    <= body_s << shamt_s;
                s1_sat_r    <= sat_s;
                s1_sat_hi_r <= run_pos_s;
                s1_zero_r   <= ~fields_s.mant[MANT_WIDTH];
                s1_nar_r    <= fields_s.nar;
                s1_sign_r   <= fields_s.sign;
                s1_sticky_r <= fields_s.sticky;
                s1_tag_r    <= tag_i;
            end
        end
    end

    posit_round_rne u_round (
        .vec       (s1_vec_r),
        .sticky    (s1_sticky_r),
        .sat       (s1_sat_r),
        .sat_hi    (s1_sat_hi_r),
        .mag       (mag_s),
        .saturated (rnd_sat_s)
    );

    // NaR outranks zero, which outranks the rounded value.
    always_comb begin
        enc_s = {1'b0, mag_s};
        if (s1_nar_r) begin
            enc_s = {1'b1, {KEPT_WIDTH{1'b0}}};
        end else if (s1_zero_r) begin
            enc_s = {POSIT_N{1'b0}};
        end else if (s1_sign_r) begin
            enc_s = (~{1'b0, mag_s}) + N_ONE;
        end else begin
            enc_s = {1'b0, mag_s};
        end
    end

    // Stage 2: output register, held while downstream stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            result_o    <= {POSIT_N{1'b0}};
            tag_o       <= {TAG_WIDTH{1'b0}};
        end else if (s2_ready_s) begin
            out_valid_o <= s1_valid_r;
            if (s1_valid_r) begin
                result_o <= enc_s;
                tag_o    <= s1_tag_r;
            end
        end
    end

`ifdef POSIT_ENC_SAT_CNT_EN
    logic        out_sat_r;
    logic [15:0] sat_cnt_r;

    // Saturation flag travels with the result; counter sticks at all ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_sat_r <= 1'b0;
            sat_cnt_r <= 16'h0000;
        end else begin
            if (s2_ready_s && s1_valid_r) begin
                out_sat_r <= rnd_sat_s & ~s1_nar_r & ~s1_zero_r;
            end
            if (out_valid_o && out_ready_i && out_sat_r && (sat_cnt_r != 16'hFFFF)) begin
                sat_cnt_r <= sat_cnt_r + 16'h0001;
            end
        end
    end

    assign sat_cnt_o = sat_cnt_r;
`else
    logic sat_unused_s;
    assign sat_unused_s = rnd_sat_s;
`endif

endmodule
